gaussian_window_gen_5x5: RTL and testbench
==========================================

Name: gaussian_window_gen_5x5

Overview:
- Builds the 25-pixel 5x5 neighbourhood consumed by the Gaussian blur stage from a raster-order greyscale stream, one pixel per clock.
- Uses four line buffers and a 5x5 register window.
- Sits between the pixel source (camera/BRAM reader) and the 5x5 Gaussian blur.
- Emits a window only where all 25 taps lie inside the image; there is no border padding.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=5)
- IMG_HEIGHT, 480, lines per frame (>=5)
- DATA_W, 8, pixel width in bits

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  in_pixel is valid this cycle
- in_sof  input  1  start of frame; qualified by in_valid; marks pixel (0,0)
- in_pixel  input  DATA_W  raster-order pixel
- p00..p44  output  DATA_W each (25 ports)  window taps; pRC = row R (0 = oldest/top), column C (0 = leftmost)
- win_valid  output  1  taps hold a complete in-image window this cycle
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- **Reset** (rst_n low at posedge): col/row counters = 0, all p* = 0, win_valid = 0, frame_done = 0. Line-buffer RAM is not cleared; stale data is masked by the valid gating.
- **Accept:** a pixel is accepted when in_valid = 1. There is no backpressure.
- **Idle:** with in_valid = 0, counters, window and line buffers hold; win_valid and frame_done are 0.
- **Position counters:**
  - col counts 0..IMG_WIDTH-1; at IMG_WIDTH-1, col wraps to 0 and row increments.
  - row counts 0..IMG_HEIGHT-1; on the last pixel both wrap to 0.
- **in_sof:** in_valid & in_sof forces the accepted pixel to position (0,0), whatever the counter state; counters then advance from there. in_sof without in_valid is ignored.
- **Line buffers:** four DATA_W x IMG_WIDTH buffers, indexed by col. On accept, read address = col.
  - LB3 supplies the pixel 1 line above, LB2 2 lines, LB1 3 lines, LB0 4 lines.
  - Write cascade: in_pixel->LB3, old LB3->LB2, old LB2->LB1, old LB1->LB0.
  - Implement as registers or read-before-write RAM; effective behaviour is the same.
- **Window:** on accept, each window row shifts left one column.
  - Column 4 is loaded with {LB0, LB1, LB2, LB3, in_pixel} for rows 0..4.
  - Result: p44 = current pixel (r,c), p00 = pixel (r-4,c-4).
- **Latency / win_valid:** win_valid registers to 1 the cycle after accepting pixel (r,c) with r>=4 and c>=4; otherwise 0.
  - Taps then hold rows r-4..r, columns c-4..c. The window centre p22 is image pixel (r-2,c-2).
  - Windows per frame = (IMG_WIDTH-4)*(IMG_HEIGHT-4).
- **Line boundary:** the window is not cleared at line start. The c>=4 gating suppresses windows that straddle two lines.
- **frame_done:** registers to 1 the cycle after accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1). It coincides with the final win_valid.
- **Back-to-back frames:** no bubble is required; frame N+1 pixel (0,0) may follow frame N's last pixel on the next clock.
- **Reset mid-frame:** the next accepted pixel is (0,0). No window is emitted until row 4 / col 4 of the new frame.
- **Arithmetic:** counters are $clog2 of the dimension in width; comparisons are exact equality to IMG_WIDTH-1 / IMG_HEIGHT-1.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- **Basic frame:** IMG_WIDTH=8, IMG_HEIGHT=6; continuous stream with pixel(r,c) = r*16+c.
  - First win_valid the cycle after accept #37 (pixel (4,4)), with p00=0x00, p22=0x22, p44=0x44.
  - Exactly 8 windows per frame; the last has p00=0x13 and p44=0x57, with frame_done high the same cycle.
- **Gapped input:** same frame with random in_valid gaps (1-5 idle cycles).
  - Window sequence is identical to the basic frame.
  - win_valid never asserts in a cycle following an idle cycle.
- **Back-to-back frames:** two frames without a gap, frame 2 pixel = 0x80+r*16+c.
  - Frame 2 first window: p00=0x80, p44=0xC4.
  - No window mixes frame 1 and frame 2 rows.
- **in_sof resync:** assert in_sof at frame-1 position (2,3), then send a full frame.
  - Counters restart there; 8 correct windows follow.
  - No win_valid until the new (4,4).
- **Reset mid-frame:** rst_n low for 1 cycle at position (4,6).
  - win_valid, frame_done and p* = 0 the next cycle.
  - The next frame produces correct windows starting p00=0x00.
- **Line-straddle check:** at row 5, cols 0..3, win_valid stays 0; row 5, col 4 window has p40=0x50 and p04=0x14.

Source files
------------

// File: rtl/gaussian_window_gen_5x5.sv
// 5x5 sliding-window generator for the Gaussian blur stage: four line buffers
// feed a 25-tap register window from a raster-order pixel stream.
module gaussian_window_gen_5x5 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_pixel,
  output logic [DATA_W-1:0] p00, p01, p02, p03, p04,
  output logic [DATA_W-1:0] p10, p11, p12, p13, p14,
  output logic [DATA_W-1:0] p20, p21, p22, p23, p24,
  output logic [DATA_W-1:0] p30, p31, p32, p33, p34,
  output logic [DATA_W-1:0] p40, p41, p42, p43, p44,
  output logic              win_valid,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]     col, cur_col;
  logic [RW-1:0]     row, cur_row;
  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb2 [IMG_WIDTH];
  logic [DATA_W-1:0] lb3 [IMG_WIDTH];
  logic [DATA_W-1:0] win [5][5];

  // in_sof overrides the counters so the accepted pixel is always (0,0).
  always_comb begin
    cur_col = col;
    cur_row = row;
    if (in_sof) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int unsigned r = 0; r < 5; r++)
        for (int unsigned c = 0; c < 5; c++)
          win[r][c] <= '0;
    end else if (in_valid) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
      for (int unsigned r = 0; r < 5; r++)
        for (int unsigned c = 0; c < 4; c++)
          win[r][c] <= win[r][c+1];
      win[0][4]  <= lb0[cur_col];
      win[1][4]  <= lb1[cur_col];
      win[2][4]  <= lb2[cur_col];
      win[3][4]  <= lb3[cur_col];
      win[4][4]  <= in_pixel;
      win_valid  <= (cur_row >= RW'(4)) && (cur_col >= CW'(4));
      frame_done <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

  // Line buffers are never reset; stale contents are masked by win_valid.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb3[cur_col] <= in_pixel;
      lb2[cur_col] <= lb3[cur_col];
      lb1[cur_col] <= lb2[cur_col];
      lb0[cur_col] <= lb1[cur_col];
    end
  end

  assign p00 = win[0][0]; assign p01 = win[0][1]; assign p02 = win[0][2];
  assign p03 = win[0][3]; assign p04 = win[0][4];
  assign p10 = win[1][0]; assign p11 = win[1][1]; assign p12 = win[1][2];
  assign p13 = win[1][3]; assign p14 = win[1][4];
  assign p20 = win[2][0]; assign p21 = win[2][1]; assign p22 = win[2][2];
  assign p23 = win[2][3]; assign p24 = win[2][4];
  assign p30 = win[3][0]; assign p31 = win[3][1]; assign p32 = win[3][2];
  assign p33 = win[3][3]; assign p34 = win[3][4];
  assign p40 = win[4][0]; assign p41 = win[4][1]; assign p42 = win[4][2];
  assign p43 = win[4][3]; assign p44 = win[4][4];

endmodule

// File: tb/tb_gaussian_window_gen_5x5.sv
// Self-checking bench for gaussian_window_gen_5x5 on an 8x6 image.
module tb_gaussian_window_gen_5x5;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic [7:0] in_pixel = '0;
  logic [7:0] p00, p01, p02, p03, p04, p10, p11, p12, p13, p14;
  logic [7:0] p20, p21, p22, p23, p24, p30, p31, p32, p33, p34;
  logic [7:0] p40, p41, p42, p43, p44;
  logic       win_valid, frame_done;
  logic [199:0] taps;

  always #5 clk = ~clk;

  gaussian_window_gen_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .p00(p00), .p01(p01), .p02(p02), .p03(p03), .p04(p04),
    .p10(p10), .p11(p11), .p12(p12), .p13(p13), .p14(p14),
    .p20(p20), .p21(p21), .p22(p22), .p23(p23), .p24(p24),
    .p30(p30), .p31(p31), .p32(p32), .p33(p33), .p34(p34),
    .p40(p40), .p41(p41), .p42(p42), .p43(p43), .p44(p44),
    .win_valid(win_valid), .frame_done(frame_done)
  );

  assign taps = {p00, p01, p02, p03, p04, p10, p11, p12, p13, p14,
                 p20, p21, p22, p23, p24, p30, p31, p32, p33, p34,
                 p40, p41, p42, p43, p44};

  int n_cmp = 0, n_bad = 0;

  // Reference model: whole-frame pixel store indexed by image position.
  logic [7:0]   fb [H][W];
  int           mr = 0, mc = 0;
  logic         ewv = 1'b0, efd = 1'b0;
  logic [199:0] etaps = '0;

  typedef struct { logic [199:0] t; logic fd; } win_t;
  win_t cap[$];

  typedef struct {
    string name; int idx;
    logic [7:0] e00, e22, e44, e40, e04; logic efd;
  } vec_t;
  vec_t tbl[5];

  function automatic logic [7:0] tap(input logic [199:0] t, input int r, input int c);
    return t[(24 - (r*5 + c))*8 +: 8];
  endfunction

  task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic sof, input logic [7:0] pix);
    int r, c;
    @(negedge clk);
    rst_n = rst; in_valid = v; in_sof = sof; in_pixel = pix;
    @(posedge clk);
    if (!rst) begin
      mr = 0; mc = 0; ewv = 1'b0; efd = 1'b0; etaps = '0;
    end else if (v) begin
      r = sof ? 0 : mr;
      c = sof ? 0 : mc;
      fb[r][c] = pix;
      ewv = (r >= 4) && (c >= 4);
      efd = (r == H-1) && (c == W-1);
      if (ewv)
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            etaps[(24 - (i*5 + j))*8 +: 8] = fb[r-4+i][c-4+j];
      c++;
      if (c == W) begin c = 0; r = (r == H-1) ? 0 : r + 1; end
      mr = r; mc = c;
    end else begin
      ewv = 1'b0; efd = 1'b0;
    end
    #1;
    chk("win_valid", 200'(win_valid), 200'(ewv));
    chk("frame_done", 200'(frame_done), 200'(efd));
    if (!rst || ewv) chk(rst ? "window taps" : "reset taps", taps, etaps);
    if (win_valid) cap.push_back('{t: taps, fd: frame_done});
  endtask

  task automatic send_frame(input int base, input int gap_max, input bit rnd);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gap_max > 0 && $urandom_range(0, 1) == 1)
          repeat ($urandom_range(1, gap_max)) step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b1, (r == 0 && c == 0), rnd ? 8'($urandom) : 8'(base + r*16 + c));
      end
  endtask

  task automatic send_partial(input int npix);
    for (int k = 0; k < npix; k++)
      step(1'b1, 1'b1, (k == 0), 8'((k / W)*16 + (k % W)));
  endtask

  task automatic expect_count(input string nm, input int start, input int n);
    chk(nm, 200'(cap.size() - start), 200'(n));
  endtask

  int s;

  initial begin
    tbl[0] = '{"first window",    0, 8'h00, 8'h22, 8'h44, 8'h40, 8'h04, 1'b0};
    tbl[1] = '{"line straddle",   4, 8'h10, 8'h32, 8'h54, 8'h50, 8'h14, 1'b0};
    tbl[2] = '{"last window",     7, 8'h13, 8'h35, 8'h57, 8'h53, 8'h17, 1'b1};
    tbl[3] = '{"gapped first",    8, 8'h00, 8'h22, 8'h44, 8'h40, 8'h04, 1'b0};
    tbl[4] = '{"frame2 first",   24, 8'h80, 8'hA2, 8'hC4, 8'hC0, 8'h84, 1'b0};

    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    s = cap.size(); send_frame(0, 0, 0);       expect_count("basic count", s, 8);
    s = cap.size(); send_frame(0, 5, 0);       expect_count("gapped count", s, 8);
    s = cap.size(); send_frame(0, 0, 0); send_frame(8'h80, 0, 0);
    expect_count("b2b count", s, 16);

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].idx >= cap.size()) begin
        chk({tbl[i].name, " missing"}, 200'(cap.size()), 200'(tbl[i].idx + 1));
      end else begin
        chk({tbl[i].name, " p00"}, 200'(tap(cap[tbl[i].idx].t, 0, 0)), 200'(tbl[i].e00));
        chk({tbl[i].name, " p22"}, 200'(tap(cap[tbl[i].idx].t, 2, 2)), 200'(tbl[i].e22));
        chk({tbl[i].name, " p44"}, 200'(tap(cap[tbl[i].idx].t, 4, 4)), 200'(tbl[i].e44));
        chk({tbl[i].name, " p40"}, 200'(tap(cap[tbl[i].idx].t, 4, 0)), 200'(tbl[i].e40));
        chk({tbl[i].name, " p04"}, 200'(tap(cap[tbl[i].idx].t, 0, 4)), 200'(tbl[i].e04));
        chk({tbl[i].name, " fd"},  200'(cap[tbl[i].idx].fd), 200'(tbl[i].efd));
      end
    end

    // in_sof resync at position (2,3) of a partial frame
    send_partial(2*W + 3);
    s = cap.size(); send_frame(0, 0, 0);       expect_count("resync count", s, 8);

    // reset pulse while pixel (4,6) is presented
    send_partial(4*W + 6);
    step(1'b0, 1'b1, 1'b0, 8'h46);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    s = cap.size(); send_frame(0, 0, 0);       expect_count("post-reset count", s, 8);
    if (cap.size() > s) begin
      chk("post-reset p00", 200'(tap(cap[s].t, 0, 0)), 200'(8'h00));
      chk("post-reset p44", 200'(tap(cap[s].t, 4, 4)), 200'(8'h44));
    end else begin
      chk("post-reset window", 200'(cap.size()), 200'(s + 1));
    end

    s = cap.size(); send_frame(0, 3, 1); send_frame(0, 0, 1);
    expect_count("random count", s, 16);
    repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
